// File: rtl/fully_pipelined_adder_pkg.sv
// fully_pipelined_adder_pkg
//   Shared definitions for the bit-serial pipelined adder.
//   - DEFAULT_WIDTH : default operand width / pipeline depth
//   - fa_result_t   : {cout, sum} pair produced by one full adder
//   - full_add()    : single-bit full adder used by every pipeline stage
package fully_pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef struct packed {
    logic cout;
    logic sum;
  } fa_result_t;

  function automatic fa_result_t full_add(input logic x, input logic y, input logic ci);
    fa_result_t r;
    r.sum  = x ^ y ^ ci;
    r.cout = (x & y) | (ci & (x ^ y));
    return r;
  endfunction

endpackage

// File: rtl/fpa_bit_stage.sv
// fpa_bit_stage
//   One stage of the ripple-carry pipeline: a full adder on a single bit
//   position followed by registers for its sum and carry-out.
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset, clears sum and cout
//     a_bit  in   operand A bit (already skewed to this stage)
//     b_bit  in   operand B bit (already skewed to this stage)
//     cin    in   carry from the previous stage's register (or carry-in)
//     sum    out  registered sum bit
//     cout   out  registered carry-out
module fpa_bit_stage
  import fully_pipelined_adder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a_bit,
  input  logic b_bit,
  input  logic cin,
  output logic sum,
  output logic cout
);

  fa_result_t fa;

  always_comb begin
    fa = full_add(a_bit, b_bit, cin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= 1'b0;
      cout <= 1'b0;
    end else begin
      sum  <= fa.sum;
      cout <= fa.cout;
    end
  end

endmodule

// File: rtl/fully_pipelined_adder.sv
// fully_pipelined_adder
//   Unsigned a + b + c computed one bit per clock stage. A new operand set is
//   accepted every cycle; {carry, s} appears WIDTH rising edges later.
//   Ports:
//     s      out  [WIDTH-1:0] registered sum, (a + b + c) mod 2^WIDTH
//     carry  out  registered carry-out (bit WIDTH of a + b + c)
//     a      in   [WIDTH-1:0] operand A
//     b      in   [WIDTH-1:0] operand B
//     c      in   carry-in
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset, clears the whole pipeline
module fully_pipelined_adder
  import fully_pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  output logic [WIDTH-1:0] s,
  output logic             carry,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             clk,
  input  logic             rst_n
);

  // carry_chain[k] feeds stage k; carry_chain[k+1] is stage k's registered carry
  logic [WIDTH:0]   carry_chain;
  logic [WIDTH-1:0] a_skew;
  logic [WIDTH-1:0] b_skew;
  logic [WIDTH-1:0] sum_stage;

  assign carry_chain[0] = c;
  assign carry          = carry_chain[WIDTH];

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_bit

    // Input skew: bit gi waits gi cycles so it meets the carry from stage gi-1
    // that belongs to the same operand set.
    if (gi == 0) begin : g_no_skew
      assign a_skew[gi] = a[gi];
      assign b_skew[gi] = b[gi];
    end else begin : g_skew
      logic [gi-1:0] a_skew_reg;
      logic [gi-1:0] b_skew_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_skew_reg <= '0;
          b_skew_reg <= '0;
        end else begin
          a_skew_reg[0] <= a[gi];
          b_skew_reg[0] <= b[gi];
          for (int j = 1; j < gi; j++) begin
            a_skew_reg[j] <= a_skew_reg[j-1];
            b_skew_reg[j] <= b_skew_reg[j-1];
          end
        end
      end

      assign a_skew[gi] = a_skew_reg[gi-1];
      assign b_skew[gi] = b_skew_reg[gi-1];
    end

    fpa_bit_stage u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .a_bit (a_skew[gi]),
      .b_bit (b_skew[gi]),
      .cin   (carry_chain[gi]),
      .sum   (sum_stage[gi]),
      .cout  (carry_chain[gi+1])
    );

    // Output deskew: early sum bits wait for the top stage so the whole
    // result leaves the pipeline on the same edge as carry.
    if (gi == WIDTH - 1) begin : g_no_deskew
      assign s[gi] = sum_stage[gi];
    end else begin : g_deskew
      localparam int DEPTH = WIDTH - 1 - gi;
      logic [DEPTH-1:0] sum_deskew_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_deskew_reg <= '0;
        end else begin
          sum_deskew_reg[0] <= sum_stage[gi];
          for (int j = 1; j < DEPTH; j++) begin
            sum_deskew_reg[j] <= sum_deskew_reg[j-1];
          end
        end
      end

      assign s[gi] = sum_deskew_reg[DEPTH-1];
    end

  end

endmodule

// File: tb/tb_fully_pipelined_adder.sv
// tb_fully_pipelined_adder
//   Scoreboard bench for three adder instances (WIDTH = 3, 1, 8) sharing clock
//   and reset. The stimulus process drives every cycle on the falling edge and
//   pushes the expected {carry, s} into a per-instance queue; the monitor pops
//   and compares just after every rising edge while the pipeline is running.
module tb_fully_pipelined_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0] a3, b3, s3;
  logic       c3, co3;
  logic [0:0] a1, b1, s1;
  logic       c1, co1;
  logic [7:0] a8, b8, s8;
  logic       c8, co8;

  fully_pipelined_adder #(.WIDTH(3)) dut3 (
    .s(s3), .carry(co3), .a(a3), .b(b3), .c(c3), .clk(clk), .rst_n(rst_n)
  );
  fully_pipelined_adder #(.WIDTH(1)) dut1 (
    .s(s1), .carry(co1), .a(a1), .b(b1), .c(c1), .clk(clk), .rst_n(rst_n)
  );
  fully_pipelined_adder #(.WIDTH(8)) dut8 (
    .s(s8), .carry(co8), .a(a8), .b(b8), .c(c8), .clk(clk), .rst_n(rst_n)
  );

  logic [3:0] q3[$];
  logic [1:0] q1[$];
  logic [8:0] q8[$];

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  int cycle = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic underflow(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no expected entry queued at cycle %0d", name, cycle);
  endtask

  // Monitor: one line per clock with all three results.
  always @(posedge clk) begin
    cycle++;
    #1;
    if (mon_en) begin
      if (q3.size() == 0) underflow("w3_queue");
      else check("w3_result", {co3, s3}, q3.pop_front());
      if (q1.size() == 0) underflow("w1_queue");
      else check("w1_result", {co1, s1}, q1.pop_front());
      if (q8.size() == 0) underflow("w8_queue");
      else check("w8_result", {co8, s8}, q8.pop_front());
      $display("[TB] cycle %0d: w3 s=%0d c=%0d | w1 s=%0d c=%0d | w8 s=%0d c=%0d",
               cycle, s3, co3, s1, co1, s8, co8);
    end
  end

  // Pipelines out of reset hold all-zero results; one extra zero entry
  // covers the edge right after release, when inputs are still zero.
  task automatic prefill();
    q3.delete(); q1.delete(); q8.delete();
    repeat (3) q3.push_back(4'd0);
    repeat (1) q1.push_back(2'd0);
    repeat (8) q8.push_back(9'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_w3"}, {co3, s3}, 0);
    check({tag, "_w1"}, {co1, s1}, 0);
    check({tag, "_w8"}, {co8, s8}, 0);
  endtask

  // One operand set per instance per cycle. Garbage is driven first to show
  // that only the value present at the rising edge matters.
  task automatic tick(input logic [2:0] ta3, input logic [2:0] tb3, input logic tc3,
                      input logic [7:0] ta8, input logic [7:0] tb8, input logic tc8);
    logic [0:0] ra1, rb1;
    logic       rc1;
    @(negedge clk);
    a3 = 3'($urandom); b3 = 3'($urandom); c3 = 1'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
    #2;
    ra1 = 1'($urandom); rb1 = 1'($urandom); rc1 = 1'($urandom);
    a3 = ta3; b3 = tb3; c3 = tc3;
    a8 = ta8; b8 = tb8; c8 = tc8;
    a1 = ra1; b1 = rb1; c1 = rc1;
    q3.push_back(4'(ta3) + 4'(tb3) + 4'(tc3));
    q8.push_back(9'(ta8) + 9'(tb8) + 9'(tc8));
    q1.push_back(2'(ra1) + 2'(rb1) + 2'(rc1));
  endtask

  task automatic tick_rand();
    tick(3'($urandom), 3'($urandom), 1'($urandom),
         8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  initial begin
    rst_n = 1'b0;
    a3 = '0; b3 = '0; c3 = 1'b0;
    a1 = '0; b1 = '0; c1 = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0;
    #12;
    check_zero("reset_state");

    prefill();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed vectors (w3 hand-checked: 5, 3, 2, 7+c, 0+c).
    tick(3'd2, 3'd3, 1'b0, 8'd255, 8'd255, 1'b1);  // w3 -> 5,   w8 -> 511
    tick(3'd1, 3'd1, 1'b1, 8'd255, 8'd0,   1'b1);  // w3 -> 3,   w8 -> 256
    tick(3'd0, 3'd2, 1'b0, 8'd100, 8'd27,  1'b0);  // w3 -> 2,   w8 -> 127
    tick(3'd7, 3'd7, 1'b1, 8'd128, 8'd128, 1'b0);  // w3 -> 15,  w8 -> 256
    tick(3'd7, 3'd0, 1'b1, 8'd0,   8'd0,   1'b0);  // w3 -> 8,   w8 -> 0
    tick(3'd0, 3'd0, 1'b0, 8'd1,   8'd1,   1'b1);  // w3 -> 0,   w8 -> 3

    repeat (30) tick_rand();

    // Load in-flight results, then reset asynchronously mid-cycle.
    tick(3'd7, 3'd7, 1'b1, 8'd255, 8'd255, 1'b1);
    tick(3'd5, 3'd6, 1'b0, 8'd200, 8'd100, 1'b1);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_zero("async_reset");
    a3 = 3'd7; b3 = 3'd7; c3 = 1'b1;
    a8 = 8'hff; b8 = 8'hff; c8 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("held_reset");

    prefill();
    @(negedge clk);
    a3 = '0; b3 = '0; c3 = 1'b0;
    a1 = '0; b1 = '0; c1 = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    tick(3'd2, 3'd3, 1'b0, 8'd15, 8'd240, 1'b1);   // w3 -> 5, w8 -> 256
    tick(3'd6, 3'd1, 1'b0, 8'd170, 8'd85, 1'b0);   // w3 -> 7, w8 -> 255
    repeat (20) tick_rand();
    repeat (8) tick(3'd0, 3'd0, 1'b0, 8'd0, 8'd0, 1'b0);

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net: the bench is fully cycle-bounded, but never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fully_pipelined_adder.md
# fully_pipelined_adder

Parameterized unsigned adder, a + b + c, built as a bit-serial ripple-carry pipeline: one bit position per stage, one register rank per stage. It accepts a new operand set every clock and returns sum and carry-out a fixed WIDTH cycles later. It serves as a high-throughput arithmetic primitive where clock rate matters more than latency.

## Interface
- WIDTH, default 8: operand/sum width in bits and pipeline depth; legal range ≥ 1.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s  output  WIDTH  registered sum bits, s = (a + b + c) mod 2^WIDTH.
- carry  output  1  registered carry-out, bit WIDTH of a + b + c.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c  input  1  carry-in.
- Positional port order is fixed: s, carry, a, b, c, clk, rst_n.

## Operation
- No handshake. Every rising edge captures {a, b, c}. Each captured set yields exactly one {s, carry} result.
- Stage k (0..WIDTH-1) is a full adder on bit k, using:
  - a[k] and b[k] delayed by k cycles through an input skew chain;
  - the carry registered by stage k-1 (stage 0 uses c).
- Stage k registers sum bit k and its carry-out.
- Sum bit k passes through a deskew chain of WIDTH-1-k registers, so all bits of one result appear together.
- carry is the registered carry-out of stage WIDTH-1.
- Arithmetic is pure unsigned binary; there is no overflow flag beyond carry.
- Maximum value: a = b = 2^WIDTH-1, c = 1 gives s = 2^WIDTH-1, carry = 1.
- WIDTH = 1 degenerates to a single registered full adder.
- The combinational path per stage is one full adder only; there is no cross-bit combinational carry.

## Timing
- Latency is WIDTH rising edges. Inputs sampled at edge N produce their result on s/carry immediately after edge N+WIDTH-1, stable until edge N+WIDTH.
- A bench that drives inputs on the falling edge and samples WIDTH clock periods later sees the matching result.
- Throughput is one result per cycle. Back-to-back operands never interfere.
- Reset:
  - rst_n low asserts immediately, without waiting for clk.
  - It clears every skew, carry, sum and deskew register, so s = 0 and carry = 0.
- After reset release:
  - The first WIDTH-1 cycles output results of all-zero operands (s = 0, carry = 0).
  - The first real result follows the stated latency.
- Reset mid-operation discards all in-flight results. No partial results are preserved.
- Inputs changing between edges have no effect; only the value at the rising edge matters.

## Structure
- No shared package is required; WIDTH is the only configuration.
- The pipeline is built with a generate loop over bit positions.
- One sub-module is natural: fpa_bit_stage, containing:
  - a full adder;
  - its sum/carry registers;
  - async active-low reset.
- Skew and deskew chains are generated shift registers in the top level, each of depth k or WIDTH-1-k per bit.

## Test plan
- WIDTH=3, reset then a=2, b=3, c=0 -> after 3 edges s=5, carry=0.
- WIDTH=3, back-to-back on consecutive cycles: (2,3,0), (1,1,1), (0,2,0) -> s = 5, 3, 2 on three consecutive cycles starting at latency 3, carry=0 throughout.
- WIDTH=3, overflow: a=7, b=7, c=1 -> s=7, carry=1.
- WIDTH=3, a=7, b=0, c=1 -> s=0, carry=1, proving the carry ripples through all stages.
- Assert rst_n low mid-stream with results in flight -> s=0 and carry=0 immediately. After release, zeros until new operands emerge WIDTH cycles after capture.
- WIDTH=1 and WIDTH=8:
  - WIDTH=8, random a, b, c each cycle -> every output equals the 9-bit sum of the operands captured WIDTH edges earlier.
  - WIDTH=1, random operands -> same check at 1-cycle latency.
